// File: rtl/rv32_fetch_stage.sv
// rv32_fetch_stage: PC holder and instruction-memory request issuer feeding decode.
// Ports: clk, reset (sync, active-high), stop, stall, branch_taken, branch_target,
//   fetch_decode_buff {pc, generate_nop}, instr_req, instr_addr, instr_ready,
//   perf_fetched, perf_bubbles (live only with `define RV32_FETCH_PERF_EN).

package rv32_pkg;
  typedef logic [31:0] rv32_word;
  typedef struct packed {
    rv32_word pc;
    logic     generate_nop;
  } fetch_decode_buffer_t;
endpackage

module rv32_fetch_stage
  import rv32_pkg::*;
#(
  parameter rv32_word RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stop,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  rv32_word             branch_target,
  output fetch_decode_buffer_t fetch_decode_buff,
  output logic                 instr_req,
  output rv32_word             instr_addr,
  input  logic                 instr_ready,
  output rv32_word             perf_fetched,
  output rv32_word             perf_bubbles
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_WAIT
  } state_t;

  state_t               state_q, state_d;
  rv32_word             pc_q, pc_d;
  fetch_decode_buffer_t buff_q, buff_d;
  logic                 hold;
  logic                 accept;
  logic                 refuse;

  // A redirect overrides a decode stall; stop overrides everything.
  assign hold = stop | (stall & ~branch_taken);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buff_d     = buff_q;
    instr_req  = 1'b0;
    instr_addr = pc_q;
    accept     = 1'b0;
    refuse     = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        if (!stop) state_d = S_RUN;
      end
      S_RUN, S_WAIT: begin
        instr_req = 1'b1;
        if (stop)
          instr_addr = buff_q.pc;
        else if (branch_taken)
          instr_addr = branch_target;
        else if (stall)
          instr_addr = buff_q.pc;
        else
          instr_addr = pc_q;
        accept = instr_ready & ~hold;
        refuse = ~instr_ready & ~hold;
        if (accept) begin
          buff_d.pc           = instr_addr;
          buff_d.generate_nop = 1'b0;
          pc_d                = instr_addr + 32'd4;
          state_d             = S_RUN;
        end else if (refuse) begin
          // Keep the refused address (possibly a branch target) for retry.
          buff_d.pc           = instr_addr;
          buff_d.generate_nop = 1'b1;
          pc_d                = instr_addr;
          state_d             = S_WAIT;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= S_BOOT;
      pc_q                <= RESET_PC;
      buff_q.pc           <= '0;
      buff_q.generate_nop <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buff_q  <= buff_d;
    end
  end

  assign fetch_decode_buff = buff_q;

`ifdef RV32_FETCH_PERF_EN
  rv32_word fetched_q;
  rv32_word bubbles_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      if (accept) fetched_q <= fetched_q + 32'd1;
      if (refuse) bubbles_q <= bubbles_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`else
  assign perf_fetched = 32'h0;
  assign perf_bubbles = 32'h0;
`endif

endmodule

// File: tb/tb_rv32_fetch_stage.sv
// tb_rv32_fetch_stage: directed bench with a reference model of the fetch rules.
// Drives rv32_fetch_stage; checks buffer, request, address and perf counters.

module tb_rv32_fetch_stage;
  import rv32_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 stop = 1'b0;
  logic                 stall = 1'b0;
  logic                 branch_taken = 1'b0;
  rv32_word             branch_target = '0;
  logic                 instr_ready = 1'b1;
  fetch_decode_buffer_t buff;
  logic                 instr_req;
  rv32_word             instr_addr;
  rv32_word             perf_fetched;
  rv32_word             perf_bubbles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32_fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk              (clk),
    .reset            (reset),
    .stop             (stop),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .fetch_decode_buff(buff),
    .instr_req        (instr_req),
    .instr_addr       (instr_addr),
    .instr_ready      (instr_ready),
    .perf_fetched     (perf_fetched),
    .perf_bubbles     (perf_bubbles)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: registered view after each edge.
  bit       m_valid = 0;
  bit       m_boot;
  rv32_word m_pc;
  rv32_word m_bpc;
  bit       m_nop;
  rv32_word m_fet;
  rv32_word m_bub;

  always @(negedge clk) begin
    rv32_word e_addr;
    bit       e_req;
    #2;
    e_req  = !m_boot;
    if (stop)              e_addr = m_bpc;
    else if (branch_taken) e_addr = branch_target;
    else if (stall)        e_addr = m_bpc;
    else                   e_addr = m_pc;
    if (!reset && m_valid) begin
      chk("m_buff_pc", buff.pc, m_bpc);
      chk("m_buff_nop", {31'b0, buff.generate_nop}, {31'b0, m_nop});
      chk("m_req", {31'b0, instr_req}, {31'b0, e_req});
      if (e_req) chk("m_addr", instr_addr, e_addr);
`ifdef RV32_FETCH_PERF_EN
      chk("m_perf_fetched", perf_fetched, m_fet);
      chk("m_perf_bubbles", perf_bubbles, m_bub);
`else
      chk("m_perf_fetched", perf_fetched, 32'h0);
      chk("m_perf_bubbles", perf_bubbles, 32'h0);
`endif
    end
    if (reset) begin
      m_valid = 1;
      m_boot  = 1;
      m_pc    = 32'h0;
      m_bpc   = 32'h0;
      m_nop   = 1;
      m_fet   = 0;
      m_bub   = 0;
    end else if (m_valid) begin
      if (m_boot) begin
        if (!stop) m_boot = 0;
      end else if (!(stop || (stall && !branch_taken))) begin
        m_bpc = e_addr;
        if (instr_ready) begin
          m_nop = 0;
          m_pc  = e_addr + 32'd4;
          m_fet = m_fet + 1;
        end else begin
          m_nop = 1;
          m_pc  = e_addr;
          m_bub = m_bub + 1;
        end
      end
    end
  end

  task automatic step(input bit rs, input bit sp, input bit sl,
                      input bit br, input rv32_word tg, input bit rdy);
    @(negedge clk);
    reset         = rs;
    stop          = sp;
    stall         = sl;
    branch_taken  = br;
    branch_target = tg;
    instr_ready   = rdy;
    #3;
  endtask

  initial begin
    repeat (3) step(1, 0, 0, 0, 0, 1);
    // boot and sequential fetch
    step(0, 0, 0, 0, 0, 1);
    chk("boot_req", {31'b0, instr_req}, 32'h0);
    chk("boot_nop", {31'b0, buff.generate_nop}, 32'h1);
    chk("boot_pc", buff.pc, 32'h0);
    step(0, 0, 0, 0, 0, 1);
    chk("seq_addr0", instr_addr, 32'h0);
    chk("seq_req", {31'b0, instr_req}, 32'h1);
    step(0, 0, 0, 0, 0, 1);
    chk("seq_buff0", buff.pc, 32'h0);
    chk("seq_addr4", instr_addr, 32'h4);
    step(0, 0, 0, 0, 0, 1);
    chk("seq_buff4", buff.pc, 32'h4);
    chk("seq_addr8", instr_addr, 32'h8);
    step(0, 0, 0, 0, 0, 1);
    // refusals at 0x10
    step(0, 0, 0, 0, 0, 0);
    chk("wait_addr_a", instr_addr, 32'h10);
    step(0, 0, 0, 0, 0, 0);
    chk("wait_addr_b", instr_addr, 32'h10);
    chk("wait_nop_a", {31'b0, buff.generate_nop}, 32'h1);
    step(0, 0, 0, 0, 0, 1);
    chk("wait_nop_b", {31'b0, buff.generate_nop}, 32'h1);
    step(0, 0, 0, 0, 0, 1);
    chk("wait_buff", buff.pc, 32'h10);
    chk("wait_next", instr_addr, 32'h14);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // decode stall with buff.pc 0x20
    step(0, 0, 1, 0, 0, 1);
    chk("stall_buff", buff.pc, 32'h20);
    chk("stall_addr_a", instr_addr, 32'h20);
    step(0, 0, 1, 0, 0, 1);
    chk("stall_addr_b", instr_addr, 32'h20);
    step(0, 0, 0, 0, 0, 1);
    chk("stall_rel", instr_addr, 32'h24);
    // branch beats stall
    step(0, 0, 1, 1, 32'h100, 1);
    chk("br_addr", instr_addr, 32'h100);
    step(0, 0, 0, 0, 0, 1);
    chk("br_buff", buff.pc, 32'h100);
    chk("br_next", instr_addr, 32'h104);
    // S_WAIT at 0x30 replaced by branch to 0x200
    step(0, 0, 0, 1, 32'h30, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("w30_addr", instr_addr, 32'h30);
    step(0, 0, 0, 1, 32'h200, 1);
    chk("w30_br", instr_addr, 32'h200);
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 1);
    chk("br200_buff", buff.pc, 32'h200);
    step(0, 0, 0, 0, 0, 1);
    chk("wrap_buff", buff.pc, 32'hFFFF_FFFC);
    chk("wrap_addr", instr_addr, 32'h0);
    // stop masks branch
    step(0, 1, 0, 1, 32'h500, 1);
    chk("stop_addr", instr_addr, 32'h0);
    step(0, 0, 0, 0, 0, 1);
    chk("stop_after", instr_addr, 32'h4);
    // misaligned target fetched as-is
    step(0, 0, 0, 1, 32'h302, 1);
    chk("mis_addr", instr_addr, 32'h302);
    step(0, 0, 0, 0, 0, 1);
    chk("mis_buff", buff.pc, 32'h302);
    chk("mis_next", instr_addr, 32'h306);
    // stop and stall with refused memory
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    // reset while waiting
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_wait_req", {31'b0, instr_req}, 32'h0);
    chk("rst_wait_nop", {31'b0, buff.generate_nop}, 32'h1);
    // 5 accepts + 2 refusals
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
`ifdef RV32_FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 32'd5);
    chk("perf_bubbles", perf_bubbles, 32'd2);
`else
    chk("perf_fetched", perf_fetched, 32'd0);
    chk("perf_bubbles", perf_bubbles, 32'd0);
`endif
    step(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
